// File: rtl/dma_xfer_ctrl_pkg.sv
// Shared types and constants for the DMA transfer controller.
// Optional feature: DMA_XFER_TIMEOUT_EN enables the bus-grant timeout.
package dma_xfer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIFO,
    ST_REQ,
    ST_BURST,
    ST_SECT_END,
    ST_FINISH
  } state_t;

  localparam int DEF_FIFO_DEPTH   = 8;
  localparam int DEF_SECTOR_WORDS = 256;
  localparam int TIMEOUT_LIMIT    = 255;
  localparam int WORD_W           = 16;

endpackage

// File: rtl/dma_xfer_ctrl_fifo.sv
// dma_word_fifo: word FIFO between data_io and the memory bus.
// Push while full and pop while empty are dropped; flush empties it.
module dma_word_fifo
  import dma_xfer_ctrl_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  parameter  int WIDTH = WORD_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Store pushed words.
  // NOTE: the storage array is deliberately not reset; count and pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps count.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: sector DMA between data_io and RAM in FIFO_DEPTH-word bursts.
// Define DMA_XFER_TIMEOUT_EN to abort (and flag err) after TIMEOUT_LIMIT
// cycles in REQ without bus_grant; otherwise REQ waits forever and err=0.
module dma_xfer_ctrl
  import dma_xfer_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SECTOR_WORDS = DEF_SECTOR_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        dir,
  input  logic [23:0] base_in,
  input  logic [7:0]  scnt_in,
  input  logic        abort,
  input  logic        dio_wr,
  input  logic [15:0] dio_wdata,
  input  logic        dio_rd,
  output logic [15:0] dio_rdata,
  output logic        dio_ready,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [22:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_dout,
  input  logic [15:0] ram_din,
  input  logic        ram_ack,
  output logic        busy,
  output logic        done,
  output logic [23:0] cur_addr,
  output logic [7:0]  cur_scnt,
  output logic        err
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WCNT_W = $clog2(SECTOR_WORDS + 1);

  state_t             state, state_nxt;
  logic               dir_r;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [WCNT_W-1:0]  word_cnt;
  logic [WCNT_W-1:0]  word_cnt_inc;
  logic               abort_pend;
  logic               take_start, beat_ack, sect_dec, go_idle, fifo_flush;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [15:0]        fifo_head;
`ifdef DMA_XFER_TIMEOUT_EN
  logic [7:0]         tmo_cnt;
  logic               tmo_hit;
  logic               err_r;
`endif

  assign word_cnt_inc = word_cnt + WCNT_W'(1);
  assign busy         = (state != ST_IDLE);
  assign bus_req      = (state == ST_REQ) || (state == ST_BURST);
  assign ram_we       = (state == ST_BURST) && !dir_r;
  assign ram_addr     = cur_addr[23:1];
  assign ram_dout     = fifo_head;
  assign dio_rdata    = fifo_head;
  assign dio_ready    = busy && (dir_r ? !fifo_empty : !fifo_full);

  dma_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (fifo_flush),
    .push      (dir_r ? beat_ack : (busy && dio_wr)),
    .push_data (dir_r ? ram_din : dio_wdata),
    .pop       (dir_r ? (busy && dio_rd) : beat_ack),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state and per-cycle strobes.
  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    beat_ack   = 1'b0;
    sect_dec   = 1'b0;
    go_idle    = 1'b0;
    fifo_flush = 1'b0;
    done       = 1'b0;
`ifdef DMA_XFER_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    unique case (state)
      ST_IDLE: if (start) begin
        take_start = 1'b1;
        fifo_flush = 1'b1;
        state_nxt  = (scnt_in == '0) ? ST_FINISH : ST_WAIT_FIFO;
      end
      ST_WAIT_FIFO: begin
        if (abort) go_idle = 1'b1;
        else if (dir_r ? (fifo_count == '0) : (fifo_count == CNT_W'(FIFO_DEPTH)))
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (abort) go_idle = 1'b1;
        else if (bus_grant) state_nxt = ST_BURST;
`ifdef DMA_XFER_TIMEOUT_EN
        else if (tmo_cnt == 8'(TIMEOUT_LIMIT - 1)) begin
          tmo_hit = 1'b1;
          go_idle = 1'b1;
        end
`endif
      end
      // An abort here is held until the outstanding word completes.
      ST_BURST: if (ram_ack) begin
        beat_ack = 1'b1;
        if (abort || abort_pend) go_idle = 1'b1;
        else if (beat_cnt == BEAT_W'(FIFO_DEPTH - 1))
          state_nxt = (word_cnt_inc == WCNT_W'(SECTOR_WORDS)) ? ST_SECT_END : ST_WAIT_FIFO;
      end
      ST_SECT_END: begin
        if (abort) go_idle = 1'b1;
        else begin
          sect_dec  = 1'b1;
          state_nxt = (cur_scnt <= 8'd1) ? ST_FINISH : ST_WAIT_FIFO;
        end
      end
      // A RAM->disk transfer finishes only once data_io has drained the FIFO.
      ST_FINISH: begin
        if (abort) go_idle = 1'b1;
        else if (!dir_r || fifo_empty) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (go_idle) begin
      state_nxt  = ST_IDLE;
      fifo_flush = 1'b1;
    end
  end

  // State register and transfer bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      dir_r      <= 1'b0;
      cur_addr   <= '0;
      cur_scnt   <= '0;
      beat_cnt   <= '0;
      word_cnt   <= '0;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      abort_pend <= (state_nxt == ST_BURST) && (abort_pend || abort);
      if (take_start) begin
        dir_r    <= dir;
        cur_addr <= base_in & 24'hFFFFFE;
        cur_scnt <= scnt_in;
        beat_cnt <= '0;
        word_cnt <= '0;
      end
      if (beat_ack) begin
        cur_addr <= cur_addr + 24'd2;
        word_cnt <= word_cnt_inc;
        beat_cnt <= (beat_cnt == BEAT_W'(FIFO_DEPTH - 1)) ? '0 : beat_cnt + BEAT_W'(1);
      end
      if (sect_dec) begin
        cur_scnt <= (cur_scnt != '0) ? cur_scnt - 8'd1 : '0;
        word_cnt <= '0;
      end
    end
  end

`ifdef DMA_XFER_TIMEOUT_EN
  // Grant-wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_REQ) ? tmo_cnt + 8'd1 : '0;
      if (take_start)   err_r <= 1'b0;
      else if (tmo_hit) err_r <= 1'b1;
    end
  end
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed self-checking bench for dma_xfer_ctrl (default parameters).
module tb_dma_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [23:0] base_in = '0;
  logic [7:0]  scnt_in = '0;
  logic        abort = 1'b0;
  logic        dio_wr = 1'b0;
  logic [15:0] dio_wdata = '0;
  logic        dio_rd = 1'b0;
  logic [15:0] dio_rdata;
  logic        dio_ready;
  logic        bus_req;
  logic        bus_grant = 1'b0;
  logic [22:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [15:0] ram_din = '0;
  logic        ram_ack = 1'b0;
  logic        busy, done, err;
  logic [23:0] cur_addr;
  logic [7:0]  cur_scnt;

  always #5 clk = ~clk;

  dma_xfer_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .base_in(base_in),
    .scnt_in(scnt_in), .abort(abort), .dio_wr(dio_wr), .dio_wdata(dio_wdata),
    .dio_rd(dio_rd), .dio_rdata(dio_rdata), .dio_ready(dio_ready),
    .bus_req(bus_req), .bus_grant(bus_grant), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_dout(ram_dout), .ram_din(ram_din), .ram_ack(ram_ack), .busy(busy),
    .done(done), .cur_addr(cur_addr), .cur_scnt(cur_scnt), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wpat(input int i);
    return 16'hC000 ^ 16'(i * 7);
  endfunction

  function automatic logic [15:0] rpat(input logic [22:0] a);
    return a[15:0] ^ {1'b0, a[22:16], 8'h5A};
  endfunction

  // Host (data_io) model.
  bit          host_wr_on = 0;
  bit          host_rd_on = 0;
  int          host_idx = 0;
  int          host_total = 0;
  logic [15:0] rd_got[$];

  always @(negedge clk) begin
    dio_wr = 1'b0;
    dio_rd = 1'b0;
    if (host_wr_on && dio_ready && host_idx < host_total) begin
      dio_wr    = 1'b1;
      dio_wdata = wpat(host_idx);
      host_idx++;
    end
    if (host_rd_on && dio_ready) begin
      dio_rd = 1'b1;
      rd_got.push_back(dio_rdata);
    end
  end

  // Memory model: ack every (ack_delay+1) cycles once granted.
  bit in_burst = 0;
  int ack_delay = 0;
  int ack_wait = 0;

  always @(negedge clk) begin
    if (in_burst && bus_req) begin
      if (ack_wait >= ack_delay) begin
        ram_ack  = 1'b1;
        ack_wait = 0;
      end else begin
        ram_ack = 1'b0;
        ack_wait++;
      end
    end else begin
      ram_ack  = 1'b0;
      ack_wait = 0;
    end
    ram_din = rpat(ram_addr);
  end

  // Transaction logger.
  logic        req_q = 1'b0;
  int          bursts = 0;
  int          done_cnt = 0;
  int          ack_total = 0;
  logic [22:0] log_addr[$];
  logic        log_we[$];
  logic [15:0] log_data[$];

  always @(posedge clk) begin
    req_q <= bus_req;
    if (!reset_n || !bus_req) in_burst <= 1'b0;
    else if (bus_grant)       in_burst <= 1'b1;
    if (reset_n) begin
      if (bus_req && !req_q) bursts <= bursts + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (in_burst && bus_req && ram_ack) begin
        ack_total <= ack_total + 1;
        log_addr.push_back(ram_addr);
        log_we.push_back(ram_we);
        log_data.push_back(ram_dout);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic d, input logic [23:0] b, input logic [7:0] s);
    start = 1'b1; dir = d; base_in = b; scnt_in = s;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_we.delete(); log_data.delete(); rd_got.delete();
    bursts = 0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cycles; i++) begin
      cyc(1);
      if (done_cnt != d0) break;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic run_write_test(input string tag);
    int d0, bad_a, bad_w, bad_d;
    clear_logs();
    d0 = done_cnt;
    host_wr_on = 1; host_rd_on = 0; host_idx = 0; host_total = 256;
    bus_grant = 1'b1; ack_delay = 0;
    pulse_start(1'b0, 24'h010000, 8'd1);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_dio_ready_wr"}, 32'(dio_ready), 32'd1);
    cyc(20);
    pulse_start(1'b1, 24'h300000, 8'd5);  // must be ignored while busy
    wait_done(tag, 3000);
    cyc(3);
    bad_a = 0; bad_w = 0; bad_d = 0;
    foreach (log_addr[k]) begin
      if (log_addr[k] !== 23'(23'h008000 + k)) bad_a++;
      if (log_we[k] !== 1'b1) bad_w++;
      if (log_data[k] !== wpat(k)) bad_d++;
    end
    check({tag, "_words"}, 32'(log_addr.size()), 32'd256);
    check({tag, "_addr_errs"}, 32'(bad_a), 32'd0);
    check({tag, "_we_errs"}, 32'(bad_w), 32'd0);
    check({tag, "_data_errs"}, 32'(bad_d), 32'd0);
    check({tag, "_bursts"}, 32'(bursts), 32'd32);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_cur_addr"}, 32'(cur_addr), 32'h010200);
    check({tag, "_cur_scnt"}, 32'(cur_scnt), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    host_wr_on = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_dio_ready"}, 32'(dio_ready), 32'd0);
    check({tag, "_cur_addr"}, 32'(cur_addr), 32'd0);
    check({tag, "_cur_scnt"}, 32'(cur_scnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, bad, hold, n0, hi;
    logic [22:0] a;

    // Reset state.
    cyc(3);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    cyc(2);

    // Disk->RAM, one sector, immediate grant/ack.
    run_write_test("wr");

    // Zero sector count: straight to FINISH, no bus request.
    clear_logs();
    d0 = done_cnt;
    pulse_start(1'b0, 24'h123457, 8'd0);
    check("z_done", 32'(done), 32'd1);
    check("z_busy", 32'(busy), 32'd1);
    check("z_cur_addr", 32'(cur_addr), 32'h123456);
    cyc(1);
    check("z_done_low", 32'(done), 32'd0);
    check("z_busy_low", 32'(busy), 32'd0);
    cyc(2);
    check("z_bus_req_never", 32'(bursts), 32'd0);
    check("z_done_pulses", 32'(done_cnt - d0), 32'd1);

    // RAM->disk, two sectors across the address wrap.
    clear_logs();
    d0 = done_cnt;
    host_rd_on = 1;
    pulse_start(1'b1, 24'hFFFFFE, 8'd2);
    wait_done("rd", 6000);
    cyc(3);
    host_rd_on = 0;
    check("rd_first_addr", 32'((log_addr.size() > 0) ? log_addr[0] : 23'h1), 32'h7FFFFF);
    check("rd_second_addr", 32'((log_addr.size() > 1) ? log_addr[1] : 23'h1), 32'h000000);
    check("rd_ram_words", 32'(log_addr.size()), 32'd512);
    check("rd_host_words", 32'(rd_got.size()), 32'd512);
    bad = 0;
    foreach (rd_got[k]) begin
      a = 23'h7FFFFF;
      a = a + 23'(k);
      if (rd_got[k] !== rpat(a)) bad++;
    end
    check("rd_data_errs", 32'(bad), 32'd0);
    bad = 0;
    foreach (log_we[k]) if (log_we[k] !== 1'b0) bad++;
    check("rd_we_errs", 32'(bad), 32'd0);
    check("rd_cur_addr", 32'(cur_addr), 32'h0003FE);
    check("rd_cur_scnt", 32'(cur_scnt), 32'd0);
    check("rd_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Abort mid-burst with a 3-cycle ack delay.
    clear_logs();
    d0 = done_cnt;
    n0 = ack_total;
    host_wr_on = 1; host_idx = 0; host_total = 256;
    ack_delay = 3;
    pulse_start(1'b0, 24'h000100, 8'd1);
    for (int i = 0; i < 200 && ack_total != n0 + 2; i++) cyc(1);
    check("ab_reached_burst", 32'(ack_total - n0), 32'd2);
    abort = 1'b1;
    n0 = ack_total;
    hold = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (ack_total != n0) break;
      hold++;
      if (!bus_req) bad++;
    end
    check("ab_req_held", 32'(bad), 32'd0);
    check("ab_hold_cycles", 32'(hold), 32'd3);
    check("ab_bus_req_after", 32'(bus_req), 32'd0);
    check("ab_busy_after", 32'(busy), 32'd0);
    check("ab_cur_addr", 32'(cur_addr), 32'h000106);
    check("ab_cur_scnt", 32'(cur_scnt), 32'd1);
    abort = 1'b0;
    host_wr_on = 0;
    ack_delay = 0;
    cyc(3);
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);

    // Grant withheld.
    bus_grant = 1'b0;
    d0 = done_cnt;
`ifdef DMA_XFER_TIMEOUT_EN
    pulse_start(1'b1, 24'h000200, 8'd1);
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      if (bus_req) hi++;
      if (!busy) break;
    end
    check("to_req_cycles", 32'(hi), 32'd255);
    check("to_err_set", 32'(err), 32'd1);
    check("to_bus_req", 32'(bus_req), 32'd0);
    check("to_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_start(1'b0, 24'h000000, 8'd0);
    check("to_err_cleared", 32'(err), 32'd0);
    cyc(3);
`else
    pulse_start(1'b1, 24'h000200, 8'd1);
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (bus_req) hi++;
    end
    check("nt_req_cycles", 32'(hi), 32'd300);
    check("nt_err_zero", 32'(err), 32'd0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("nt_abort_busy", 32'(busy), 32'd0);
    check("nt_abort_req", 32'(bus_req), 32'd0);
    cyc(2);
    check("nt_no_done", 32'(done_cnt - d0), 32'd0);
`endif
    bus_grant = 1'b1;

    // Reset during a burst, then a clean transfer.
    clear_logs();
    n0 = ack_total;
    host_wr_on = 1; host_idx = 0; host_total = 256;
    pulse_start(1'b0, 24'h040000, 8'd1);
    for (int i = 0; i < 200 && (ack_total - n0) < 10; i++) cyc(1);
    check("mr_in_burst", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    cyc(1);
    check_reset_outputs("mr");
    host_wr_on = 0;
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    run_write_test("wr2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
